// File: rtl/fxp_pkg.sv
// Shared types and helpers for the sign-magnitude fixed-point arithmetic unit.
// Holds the opcode and FSM state enums and the max-magnitude word builder.
package fxp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_SUB = 2'b11
    } fxp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MUL2 = 2'd2,
        ST_DIV  = 2'd3
    } fxp_state_e;

    localparam int FXP_MAX_W = 128;

    // Positive word of width n with every magnitude bit set; callers slice to N.
    function automatic logic [FXP_MAX_W-1:0] fxp_max_word(input int n);
        logic [FXP_MAX_W-1:0] w;
        w = '0;
        for (int i = 0; i < FXP_MAX_W; i++) begin
            if (i < n - 1) begin
                w[i] = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fxp_serial_div.sv
// Restoring serial divider: one quotient bit per cycle over N-1+Q iterations.
// valid rises after the last iteration and holds until the next load.
module fxp_serial_div
    import fxp_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N+Q-2:0]   dividend,
    input  logic [N-2:0]     divisor,
    output logic [N-2:0]     quotient,
    output logic             ovf,
    output logic             valid
);

    localparam int I  = N - 1 + Q;
    localparam int CW = $clog2(I + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(I - 1);

    // dq_reg shifts dividend bits out of the top and quotient bits in at the bottom.
    logic [I-1:0]  dq_reg;
    logic [N-2:0]  rem_reg;
    logic [N-2:0]  dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          run_reg;
    logic          valid_reg;

    logic [N-1:0]  rem_shift;
    logic [N-1:0]  rem_sub;
    logic [N-1:0]  rem_next;
    logic          ge;
    logic          unused_rem_msb;

    always_comb begin
        rem_shift = {rem_reg, dq_reg[I-1]};
        ge        = (rem_shift >= {1'b0, dvs_reg});
        rem_sub   = rem_shift - {1'b0, dvs_reg};
        rem_next  = ge ? rem_sub : rem_shift;
    end

    // The restored remainder is always below the divisor, so its top bit is zero.
    assign unused_rem_msb = rem_next[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            dq_reg    <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else if (load) begin
            dq_reg    <= dividend;
            rem_reg   <= '0;
            dvs_reg   <= divisor;
            cnt_reg   <= '0;
            run_reg   <= 1'b1;
            valid_reg <= 1'b0;
        end else if (run_reg) begin
            dq_reg  <= {dq_reg[I-2:0], ge};
            rem_reg <= rem_next[N-2:0];
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_CNT) begin
                run_reg   <= 1'b0;
                valid_reg <= 1'b1;
            end
        end
    end

    assign quotient = dq_reg[N-2:0];
    assign ovf      = |dq_reg[I-1:N-1];
    assign valid    = valid_reg;

endmodule

// File: rtl/fxp_arith_unit.sv
// Sign-magnitude Q-format add/sub/mul/div unit behind a start/busy/done handshake.
// Define FXP_SATURATE_EN to clamp overflowing results to max magnitude.
module fxp_arith_unit
    import fxp_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] c,
    output logic         ovf,
    output logic         dbz
);

`ifdef FXP_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [FXP_MAX_W-1:0] MAX_WORD = fxp_max_word(N);
    localparam logic [N-2:0]         MAX_MAG  = MAX_WORD[N-2:0];

    fxp_state_e     state_reg;
    fxp_op_e        op_reg;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [2*N-3:0] prod_reg;
    logic [N-1:0]   c_reg;
    logic           ovf_reg;
    logic           dbz_reg;
    logic           done_reg;

    logic           accept;
    logic           div_load;
    logic           sign_a;
    logic           sign_b;
    logic           sign_b_eff;
    logic [N-2:0]   mag_a;
    logic [N-2:0]   mag_b;
    logic [N-1:0]   mag_sum;
    logic           as_sign;
    logic [N-2:0]   as_mag;
    logic           as_ovf;
    logic [2*N-3:0] mul_shift;
    logic [N-2:0]   mul_mag;
    logic           mul_ovf;
    logic [N-2:0]   div_quot;
    logic           div_ovf;
    logic           div_valid;

    // Saturate when enabled, then fold any negative zero to positive zero.
    function automatic logic [N-1:0] pack_result(input logic sign, input logic [N-2:0] mag,
                                                 input logic ovf_flag);
        logic [N-2:0] m;
        m = mag;
        if (ovf_flag && SAT_EN) begin
            m = MAX_MAG;
        end
        return (m == '0) ? {1'b0, m} : {sign, m};
    endfunction

    assign accept   = (state_reg == ST_IDLE) && start;
    assign div_load = accept && (fxp_op_e'(opcode) == OP_DIV) && (b[N-2:0] != '0);

    assign sign_a = a_reg[N-1];
    assign sign_b = b_reg[N-1];
    assign mag_a  = a_reg[N-2:0];
    assign mag_b  = b_reg[N-2:0];

    always_comb begin
        sign_b_eff = sign_b ^ (op_reg == OP_SUB);
        mag_sum    = {1'b0, mag_a} + {1'b0, mag_b};
        as_ovf     = 1'b0;
        as_sign    = sign_a;
        as_mag     = mag_sum[N-2:0];
        if (sign_a == sign_b_eff) begin
            as_ovf = mag_sum[N-1];
        end else if (mag_a >= mag_b) begin
            as_mag = mag_a - mag_b;
        end else begin
            as_mag  = mag_b - mag_a;
            as_sign = sign_b_eff;
        end
    end

    // Product is aligned by dropping Q fraction bits; anything above N-1 bits overflows.
    always_comb begin
        mul_shift = prod_reg >> Q;
        mul_mag   = mul_shift[N-2:0];
        mul_ovf   = |mul_shift[2*N-3:N-1];
    end

    fxp_serial_div #(
        .N(N),
        .Q(Q)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend ({a[N-2:0], {Q{1'b0}}}),
        .divisor  (b[N-2:0]),
        .quotient (div_quot),
        .ovf      (div_ovf),
        .valid    (div_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_ADD;
            a_reg     <= '0;
            b_reg     <= '0;
            prod_reg  <= '0;
            c_reg     <= '0;
            ovf_reg   <= 1'b0;
            dbz_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg    <= fxp_op_e'(opcode);
                        a_reg     <= a;
                        b_reg     <= b;
                        state_reg <= div_load ? ST_DIV : ST_ALU;
                    end
                end
                ST_ALU: begin
                    if (op_reg == OP_MUL) begin
                        prod_reg  <= {{(N-1){1'b0}}, mag_a} * {{(N-1){1'b0}}, mag_b};
                        state_reg <= ST_MUL2;
                    end else begin
                        // Only a zero-divisor divide reaches ALU with a divide opcode.
                        if (op_reg == OP_DIV) begin
                            c_reg   <= {sign_a, MAX_MAG};
                            ovf_reg <= 1'b1;
                            dbz_reg <= 1'b1;
                        end else begin
                            c_reg   <= pack_result(as_sign, as_mag, as_ovf);
                            ovf_reg <= as_ovf;
                            dbz_reg <= 1'b0;
                        end
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_MUL2: begin
                    c_reg     <= pack_result(sign_a ^ sign_b, mul_mag, mul_ovf);
                    ovf_reg   <= mul_ovf;
                    dbz_reg   <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                ST_DIV: begin
                    if (div_valid) begin
                        c_reg     <= pack_result(sign_a ^ sign_b, div_quot, div_ovf);
                        ovf_reg   <= div_ovf;
                        dbz_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;
    assign c    = c_reg;
    assign ovf  = ovf_reg;
    assign dbz  = dbz_reg;

endmodule

// File: tb/tb_fxp_arith_unit.sv
// Self-checking bench for fxp_arith_unit (N=32, Q=15): directed cases plus
// randomized operations checked against an integer-arithmetic reference model.
module tb_fxp_arith_unit;

`ifdef FXP_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] T_ADD = 2'b00;
    localparam logic [1:0] T_MUL = 2'b01;
    localparam logic [1:0] T_DIV = 2'b10;
    localparam logic [1:0] T_SUB = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] c;
    logic        ovf;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    fxp_arith_unit #(
        .N(32),
        .Q(15)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .c      (c),
        .ovf    (ovf),
        .dbz    (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: real-number rules on integer magnitudes, no cycle detail.
    function automatic void model(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] ec, output bit eovf, output bit edbz,
                                  output int elat);
        longint unsigned ma, mb, r, mag;
        longint unsigned maxm;
        bit sa, sb, sg;
        maxm = 64'h7FFF_FFFF;
        sa   = av[31];
        sb   = bv[31];
        ma   = 64'(av[30:0]);
        mb   = 64'(bv[30:0]);
        edbz = 1'b0;
        r    = 0;
        sg   = 1'b0;
        elat = 1;
        case (op)
            T_ADD, T_SUB: begin
                if (op == T_SUB) sb = ~sb;
                if (sa == sb) begin
                    r = ma + mb; sg = sa;
                end else if (ma >= mb) begin
                    r = ma - mb; sg = sa;
                end else begin
                    r = mb - ma; sg = sb;
                end
                elat = 1;
            end
            T_MUL: begin
                r = (ma * mb) >> 15; sg = sa ^ sb; elat = 2;
            end
            default: begin
                if (mb == 0) begin
                    edbz = 1'b1; r = maxm + 1; sg = sa; elat = 1;
                end else begin
                    r = (ma << 15) / mb; sg = sa ^ sb; elat = 47;
                end
            end
        endcase
        eovf = (r > maxm);
        mag  = r & maxm;
        if (edbz || (eovf && SAT)) mag = maxm;
        if (mag == 0) sg = 1'b0;
        ec = {sg, mag[30:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [30:0] m;
        case ($urandom_range(0, 3))
            0:       m = 31'($urandom_range(0, 32'h1FFFF));
            1:       m = 31'($urandom);
            2:       m = ($urandom_range(0, 1) != 0) ? 31'h8000 : 31'h0;
            default: m = 31'($urandom_range(0, 32'hFFFFFF));
        endcase
        return {1'($urandom), m};
    endfunction

    // Entered and left at #1 after a rising edge with the unit idle.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_c, input bit exp_ovf,
                          input bit exp_dbz, input int exp_lat, input bit mid_pulse);
        int lat;
        bit busy_ok;
        start  = 1'b1;
        opcode = op;
        a      = av;
        b      = bv;
        @(posedge clk); #1;
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        opcode  = 2'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = mid_pulse && (lat == 20);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        $display("%-10s op=%0d a=%08h b=%08h -> c=%08h ovf=%0b dbz=%0b lat=%0d",
                 name, op, av, bv, c, ovf, dbz, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (100 = timeout), expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (c !== exp_c) begin
            errors++;
            $display("FAIL %s c: got %08h, expected %08h", name, c, exp_c);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: got %0b, expected %0b", name, ovf, exp_ovf);
        end
        checks++;
        if (dbz !== exp_dbz) begin
            errors++;
            $display("FAIL %s dbz: got %0b, expected %0b", name, dbz, exp_dbz);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_during: busy dropped before done, expected 1 throughout", name);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %0b, expected 0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || c !== exp_c) begin
            errors++;
            $display("FAIL %s pulse_hold: done=%0b c=%08h, expected done=0 c=%08h",
                     name, done, c, exp_c);
        end
    endtask

    task automatic run_model(input string name, input logic [1:0] op, input logic [31:0] av,
                             input logic [31:0] bv, input bit mid_pulse);
        logic [31:0] ec;
        bit eo, ed;
        int el;
        model(op, av, bv, ec, eo, ed, el);
        run_op(name, op, av, bv, ec, eo, ed, el, mid_pulse);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || c !== 32'h0 || ovf !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b c=%08h ovf=%0b dbz=%0b, expected all zero",
                     name, busy, done, c, ovf, dbz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opcode = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        run_op("add", T_ADD, 32'h0000_C000, 32'h0001_2000, 32'h0001_E000, 1'b0, 1'b0, 1, 1'b0);
        run_op("sub", T_SUB, 32'h0000_8000, 32'h0001_8000, 32'h8001_0000, 1'b0, 1'b0, 1, 1'b0);
        run_op("sub_zero", T_SUB, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b0);
        run_op("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'h0000_0001,
               SAT ? 32'h7FFF_FFFF : 32'h0000_0000, 1'b1, 1'b0, 1, 1'b0);
    endtask

    task automatic test_mul();
        run_op("mul", T_MUL, 32'h8000_C000, 32'h0001_0000, 32'h8001_8000, 1'b0, 1'b0, 2, 1'b0);
        run_op("mul_ovf", T_MUL, 32'h4000_0000, 32'h0002_0000,
               SAT ? 32'h7FFF_FFFF : 32'h0000_0000, 1'b1, 1'b0, 2, 1'b0);
    endtask

    task automatic test_div();
        run_op("div", T_DIV, 32'h0001_8000, 32'h8000_4000, 32'h8003_0000, 1'b0, 1'b0, 47, 1'b1);
        run_op("div_zero", T_DIV, 32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 1'b0);
    endtask

    task automatic test_abort();
        int pulses;
        start = 1'b1; opcode = T_DIV; a = 32'h0001_8000; b = 32'h8000_4000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("abort");
        pulses = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", pulses);
        end
        run_op("post_abort", T_ADD, 32'h0000_C000, 32'h0001_2000, 32'h0001_E000, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_rst_start();
        rst = 1'b1; start = 1'b1; opcode = T_ADD; a = 32'h0000_C000; b = 32'h0001_2000;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_idle_outputs("rst_start");
        @(posedge clk); #1;
        check_idle_outputs("rst_start_next");
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [31:0] av, bv;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            av = rand_operand();
            bv = rand_operand();
            run_model("random", op, av, bv, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_model("b2b_div", T_DIV, 32'h0000_4000, 32'h0000_C000, 1'b0);
        run_model("b2b_mul", T_MUL, 32'h8000_6000, 32'h8000_A000, 1'b0);
        run_model("b2b_sub", T_SUB, 32'h8000_1000, 32'h8000_3000, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 2'b00; a = '0; b = '0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_abort();
        test_rst_start();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fxp_arith_unit.md
# fxp_arith_unit

Parametrised sign-magnitude fixed-point arithmetic unit performing add, subtract, multiply and divide behind a single start/busy/done handshake. It is the next-generation replacement for the current floating/fixed-point top. Width and fraction bits are generic, and the divider is a multi-cycle serial engine rather than an asynchronous side block. Operation results carry overflow and divide-by-zero status.

## Interface
- N, 32: total word width in bits; MSB is sign, N-1 magnitude bits.
- Q, 15: fraction bits; legal range 1 ≤ Q ≤ N-2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- opcode  in  2  00 add, 01 mul, 10 div, 11 sub; sampled at acceptance.
- a  in  N  operand A, sign-magnitude Q-format; sampled at acceptance.
- b  in  N  operand B, sign-magnitude Q-format; sampled at acceptance.
- busy  out  1  high from the acceptance edge until the done edge.
- done  out  1  one-cycle pulse; c, ovf and dbz are valid in that cycle.
- c  out  N  result; held until the next done.
- ovf  out  1  overflow status of the last operation; held.
- dbz  out  1  divide-by-zero status of the last operation; held.

## Operation
- States: IDLE, ALU, MUL2, DIV.
- IDLE + start → latch opcode, a and b; go to ALU (add/sub/mul) or DIV (div, divisor magnitude ≠ 0).
- Div with divisor magnitude 0 → ALU, which completes the zero-divide result.
- start is ignored while busy. Operand changes while busy have no effect.
- Add: equal signs → add magnitudes, keep the sign. Unequal signs → subtract the smaller magnitude from the larger; the result takes the sign of the larger.
- Sub: add with b's sign inverted.
- Mul: 2(N-1)-bit magnitude product; result = bits [Q+N-2:Q], truncated toward zero. Sign = sa XOR sb. ovf if any product bit above Q+N-2 is set.
- Div: restoring serial division of (|a| << Q) by |b|, one quotient bit per cycle, I = N-1+Q iterations. ovf if any quotient bit above N-2 is set. Sign = sa XOR sb.
- Divide by zero: c = sign(a) with all magnitude bits set, dbz=1, ovf=1. Sign handling is identical with or without saturation.
- Add ovf: carry out of the N-1 magnitude bits.
- Zero result: sign forced to 0; negative zero is never output.
- dbz=0 for every operation except divide by zero.

## Timing
- Reset: state IDLE, c=0, busy=0, done=0, ovf=0, dbz=0, divider counter 0.
- Acceptance edge k = the first edge with start=1 in IDLE; busy=1 from edge k.
- Add/sub and divide-by-zero: c and status registered at edge k+1; done=1 during cycle k+1..k+2.
- Mul: ALU registers the product, MUL2 registers c; done after edge k+2.
- Div: done after edge k+I+1. For N=32, Q=15 that is edge k+47.
- At the done edge: busy→0, state→IDLE. The next acceptance is possible at the edge following the done edge.
- rst asserted mid-operation: abort immediately, all outputs return to reset values, no done pulse.
- rst and start at the same edge: rst wins.

## Configuration
- FXP_SATURATE_EN defined: on ovf, c = sign with all magnitude bits set (max magnitude).
- FXP_SATURATE_EN undefined: on ovf, c = the truncated low N-1 magnitude bits with the computed sign.
- ovf and dbz are asserted identically in both builds.

## Structure
- Package fxp_pkg holds:
  - opcode enum: OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_SUB=2'b11.
  - FSM state enum.
  - a function building the max-magnitude word for a given N.
- Sub-module fxp_serial_div (params N, Q): inputs load, dividend magnitude, divisor magnitude; outputs quotient, ovf, valid. It contains the shift/subtract register and iteration counter.
- Add/sub/mul logic stays inline in fxp_arith_unit.

## Test plan
Default N=32, Q=15; 1.0 = 0x0000_8000.
- Add 0x0000_C000 (1.5) + 0x0001_2000 (2.25) → c=0x0001_E000, done one cycle after acceptance, ovf=0.
- Sub 0x0000_8000 (1.0) − 0x0001_8000 (3.0) → c=0x8001_0000 (−2.0). Sub 0x0000_8000 − 0x0000_8000 → c=0x0000_0000 (no negative zero).
- Mul 0x8000_C000 (−1.5) × 0x0001_0000 (2.0) → c=0x8001_8000 at acceptance+2. Mul 0x4000_0000 × 0x0002_0000 → ovf=1; with FXP_SATURATE_EN, c=0x7FFF_FFFF.
- Div 0x0001_8000 (3.0) ÷ 0x8000_4000 (−0.5) → c=0x8003_0000 at acceptance+47, busy high for 47 cycles. A start pulse issued mid-divide is ignored.
- Div 0x8000_8000 ÷ 0x0000_0000 → c=0xFFFF_FFFF, dbz=1, ovf=1, done at acceptance+1.
- rst asserted 10 cycles into a divide → next cycle busy=0, c=0, and no done pulse appears; a subsequent add then completes normally.
